// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the Wishbone master bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } bridge_state_e;

  localparam logic [31:0] WB_ERROR_DATA = 32'hFFFF_FFFF;

  function automatic int timeout_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_master_bridge_timeout.sv
// Bus-cycle timeout counter: counts while run is high, flags the last allowed cycle.
module wb_timeout_counter
  import wb_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

  // A zero timeout means the bus cycle may wait forever.
  assign expired = (TIMEOUT_CYCLES != 0) && run && (count == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Turns enable/busy requests into Wishbone B4 classic single-beat cycles with timeout.
// Optional sticky error status ports when WB_BRIDGE_ERROR_STATUS_EN is defined.
//
// state  | meaning
// IDLE   | waiting for reqEnable, reqBusy=1
// ACTIVE | bus cycle in progress, waiting for ack/err/timeout
// DONE   | one-cycle completion, reqBusy=0 and reqDataRead valid
module wb_master_bridge
  import wb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef WB_BRIDGE_ERROR_STATUS_EN
  input  logic                  errorClear,
  output logic                  errorFlag,
  output logic [ADDR_WIDTH-1:0] errorAddress,
`endif
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [3:0]            reqByteSelect,
  input  logic                  reqEnable,
  input  logic                  reqWriteEnable,
  input  logic [31:0]           reqDataWrite,
  output logic [31:0]           reqDataRead,
  output logic                  reqBusy,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  bridge_state_e state;
  logic          in_active;
  logic          bus_err;
  logic          bus_ack;
  logic          expired;
  logic          exiting;

  assign in_active = (state == ACTIVE);
  assign bus_err   = in_active && wb_err_i;
  assign bus_ack   = in_active && wb_ack_i;
  assign exiting   = bus_err || bus_ack || expired;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (in_active),
    .clear  (exiting),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      reqBusy     <= 1'b1;
      reqDataRead <= WB_ERROR_DATA;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= '0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          reqBusy <= 1'b1;
          if (reqEnable) begin
            wb_adr_o <= reqAddress;
            wb_sel_o <= reqByteSelect;
            wb_we_o  <= reqWriteEnable;
            wb_dat_o <= reqDataWrite;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (exiting) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            reqBusy     <= 1'b0;
            // err wins over a simultaneous ack; timeout also reports error data
            reqDataRead <= (bus_ack && !bus_err) ? wb_dat_i : WB_ERROR_DATA;
            state       <= DONE;
          end
        end
        DONE: begin
          reqBusy <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_BRIDGE_ERROR_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      errorFlag    <= 1'b0;
      errorAddress <= '0;
    end else if (bus_err || (expired && !bus_ack)) begin
      errorFlag    <= 1'b1;
      errorAddress <= wb_adr_o;
    end else if (errorClear) begin
      errorFlag    <= 1'b0;
      errorAddress <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: vector table plus multi-cycle corner sequences.
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] reqAddress;
  logic [3:0]  reqByteSelect;
  logic        reqEnable;
  logic        reqWriteEnable;
  logic [31:0] reqDataWrite;
  logic [31:0] reqDataRead;
  logic        reqBusy;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [27:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  // Second instance with the timeout disabled, sharing all stimulus.
  logic [31:0] d0_dataRead;
  logic        d0_busy, d0_cyc, d0_stb, d0_we;
  logic [3:0]  d0_sel;
  logic [27:0] d0_adr;
  logic [31:0] d0_dat;

`ifdef WB_BRIDGE_ERROR_STATUS_EN
  logic        errorClear;
  logic        errorFlag, d0_errorFlag;
  logic [27:0] errorAddress, d0_errorAddress;
`endif

  int checks = 0;
  int errors = 0;
  int starts_100 = 0;
  logic prev_cyc = 1'b0;

  always #5 clk = ~clk;

  wb_master_bridge #(.ADDR_WIDTH(28), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
`ifdef WB_BRIDGE_ERROR_STATUS_EN
    .errorClear(errorClear), .errorFlag(errorFlag), .errorAddress(errorAddress),
`endif
    .reqAddress(reqAddress), .reqByteSelect(reqByteSelect), .reqEnable(reqEnable),
    .reqWriteEnable(reqWriteEnable), .reqDataWrite(reqDataWrite),
    .reqDataRead(reqDataRead), .reqBusy(reqBusy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  wb_master_bridge #(.ADDR_WIDTH(28), .TIMEOUT_CYCLES(0)) dut_no_to (
    .clk(clk), .rst(rst),
`ifdef WB_BRIDGE_ERROR_STATUS_EN
    .errorClear(errorClear), .errorFlag(d0_errorFlag), .errorAddress(d0_errorAddress),
`endif
    .reqAddress(reqAddress), .reqByteSelect(reqByteSelect), .reqEnable(reqEnable),
    .reqWriteEnable(reqWriteEnable), .reqDataWrite(reqDataWrite),
    .reqDataRead(d0_dataRead), .reqBusy(d0_busy),
    .wb_cyc_o(d0_cyc), .wb_stb_o(d0_stb), .wb_we_o(d0_we), .wb_sel_o(d0_sel),
    .wb_adr_o(d0_adr), .wb_dat_o(d0_dat), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // Count bus-cycle starts to address 0x100 to catch duplicate issue.
  always @(negedge clk) begin
    if (wb_cyc_o && !prev_cyc && wb_adr_o == 28'h100) starts_100 <= starts_100 + 1;
    prev_cyc <= wb_cyc_o;
  end

  typedef struct {
    logic [27:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    int          resp_cycle;
    logic        ack;
    logic        err;
    logic [31:0] slave_data;
    logic [31:0] exp_data;
    int          exp_edges;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int edges;
    tick();
    reqAddress = v.addr; reqByteSelect = v.sel; reqWriteEnable = v.we;
    reqDataWrite = v.wdata; reqEnable = 1'b1;
    tick();
    edges = 1;
    chk($sformatf("v%0d cyc", idx), 32'(wb_cyc_o), 32'd1);
    chk($sformatf("v%0d stb", idx), 32'(wb_stb_o), 32'd1);
    chk($sformatf("v%0d adr", idx), 32'(wb_adr_o), 32'(v.addr));
    chk($sformatf("v%0d we", idx), 32'(wb_we_o), 32'(v.we));
    chk($sformatf("v%0d sel", idx), 32'(wb_sel_o), 32'(v.sel));
    chk($sformatf("v%0d dat_o", idx), wb_dat_o, v.wdata);
    chk($sformatf("v%0d busy_active", idx), 32'(reqBusy), 32'd1);
    // Change request inputs: the bridge must ignore them while ACTIVE.
    reqEnable = 1'b0; reqAddress = 28'hFFF_FFFF; reqWriteEnable = ~v.we;
    for (int k = 1; k < v.resp_cycle; k++) begin
      tick();
      edges++;
    end
    chk($sformatf("v%0d adr_held", idx), 32'(wb_adr_o), 32'(v.addr));
    chk($sformatf("v%0d cyc_held", idx), 32'(wb_cyc_o), 32'd1);
    wb_ack_i = v.ack; wb_err_i = v.err; wb_dat_i = v.slave_data;
    tick();
    edges++;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
    chk($sformatf("v%0d busy_done", idx), 32'(reqBusy), 32'd0);
    chk($sformatf("v%0d latency", idx), 32'(edges), 32'(v.exp_edges));
    chk($sformatf("v%0d cyc_done", idx), 32'(wb_cyc_o), 32'd0);
    chk($sformatf("v%0d stb_done", idx), 32'(wb_stb_o), 32'd0);
    chk($sformatf("v%0d data", idx), reqDataRead, v.exp_data);
    tick();
    chk($sformatf("v%0d busy_after", idx), 32'(reqBusy), 32'd1);
    chk($sformatf("v%0d data_kept", idx), reqDataRead, v.exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc_cnt;
    logic got_done;

    vecs[0] = '{28'h0001004, 4'hF, 1'b0, 32'h0, 2, 1'b1, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 3};
    vecs[1] = '{28'h0000010, 4'b0011, 1'b1, 32'h1234_5678, 1, 1'b1, 1'b0, 32'h0000_00A5, 32'h0000_00A5, 2};
    vecs[2] = '{28'h0000400, 4'h1, 1'b0, 32'h0, 3, 1'b0, 1'b1, 32'h5555_5555, 32'hFFFF_FFFF, 4};
    vecs[3] = '{28'h0002468, 4'hC, 1'b0, 32'h0, 1, 1'b1, 1'b1, 32'h1111_2222, 32'hFFFF_FFFF, 2};
    vecs[4] = '{28'hABCDEF0, 4'h6, 1'b1, 32'hDEAD_0001, 5, 1'b1, 1'b0, 32'h5A5A_1234, 32'h5A5A_1234, 6};

    rst = 1'b1; reqAddress = '0; reqByteSelect = '0; reqEnable = 1'b0;
    reqWriteEnable = 1'b0; reqDataWrite = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
`ifdef WB_BRIDGE_ERROR_STATUS_EN
    errorClear = 1'b0;
`endif
    repeat (3) tick();
    chk("rst busy", 32'(reqBusy), 32'd1);
    chk("rst data", reqDataRead, 32'hFFFF_FFFF);
    chk("rst cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst stb", 32'(wb_stb_o), 32'd0);
    chk("rst we", 32'(wb_we_o), 32'd0);
    chk("rst sel", 32'(wb_sel_o), 32'd0);
    chk("rst adr", 32'(wb_adr_o), 32'd0);
    chk("rst dat_o", wb_dat_o, 32'd0);
`ifdef WB_BRIDGE_ERROR_STATUS_EN
    chk("rst errflag", 32'(errorFlag), 32'd0);
    chk("rst erraddr", 32'(errorAddress), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Spurious ack/err while idle.
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h0000_1234;
    tick();
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
    chk("spur busy", 32'(reqBusy), 32'd1);
    chk("spur cyc", 32'(wb_cyc_o), 32'd0);
    chk("spur data", reqDataRead, 32'h5A5A_1234);

`ifdef WB_BRIDGE_ERROR_STATUS_EN
    chk("err flag", 32'(errorFlag), 32'd1);
    chk("err addr", 32'(errorAddress), 32'h0002468);
    errorClear = 1'b1;
    tick();
    errorClear = 1'b0;
    chk("err flag clr", 32'(errorFlag), 32'd0);
    chk("err addr clr", 32'(errorAddress), 32'd0);
`endif

    // Back-to-back with reqEnable held and address changed during DONE.
    reqAddress = 28'h100; reqByteSelect = 4'hF; reqWriteEnable = 1'b0; reqEnable = 1'b1;
    tick();
    chk("b2b first adr", 32'(wb_adr_o), 32'h100);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0011;
    tick();
    wb_ack_i = 1'b0;
    chk("b2b done busy", 32'(reqBusy), 32'd0);
    chk("b2b done cyc", 32'(wb_cyc_o), 32'd0);
    chk("b2b done data", reqDataRead, 32'h0000_0011);
    reqAddress = 28'h104;
    tick();
    chk("b2b idle cyc", 32'(wb_cyc_o), 32'd0);
    chk("b2b idle busy", 32'(reqBusy), 32'd1);
    tick();
    chk("b2b second cyc", 32'(wb_cyc_o), 32'd1);
    chk("b2b second adr", 32'(wb_adr_o), 32'h104);
    reqEnable = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0022;
    tick();
    wb_ack_i = 1'b0;
    chk("b2b second data", reqDataRead, 32'h0000_0022);
    tick();
    tick();
    chk("b2b no dup 0x100", 32'(starts_100), 32'd1);

    // Reset during the third ACTIVE cycle, then a late ack.
    reqAddress = 28'h200; reqEnable = 1'b1;
    tick();
    reqEnable = 1'b0;
    tick();
    tick();
    chk("rstmid cyc before", 32'(wb_cyc_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid cyc", 32'(wb_cyc_o), 32'd0);
    chk("rstmid stb", 32'(wb_stb_o), 32'd0);
    chk("rstmid busy", 32'(reqBusy), 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0077;
    tick();
    wb_ack_i = 1'b0;
    chk("rstmid late ack busy", 32'(reqBusy), 32'd1);
    tick();
    chk("rstmid busy stays", 32'(reqBusy), 32'd1);
    chk("rstmid cyc stays", 32'(wb_cyc_o), 32'd0);
    chk("rstmid data", reqDataRead, 32'hFFFF_FFFF);

    // Timeout: no ack ever arrives.
    reqAddress = 28'h0ABCDEF; reqEnable = 1'b1;
    cyc_cnt = 0;
    got_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      reqEnable = 1'b0;
      if (wb_cyc_o) cyc_cnt++;
      if (!reqBusy) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("timeout done seen", 32'(got_done), 32'd1);
    chk("timeout cyc cycles", 32'(cyc_cnt), 32'd8);
    chk("timeout data", reqDataRead, 32'hFFFF_FFFF);
    chk("timeout cyc dropped", 32'(wb_cyc_o), 32'd0);
`ifdef WB_BRIDGE_ERROR_STATUS_EN
    chk("timeout err flag", 32'(errorFlag), 32'd1);
    chk("timeout err addr", 32'(errorAddress), 32'h0ABCDEF);
`endif

    repeat (1000) tick();
    chk("no timeout cyc", 32'(d0_cyc), 32'd1);
    chk("no timeout busy", 32'(d0_busy), 32'd1);
    chk("no timeout adr", 32'(d0_adr), 32'h0ABCDEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Sequences the core-side WB request channel (enable/busy handshake from the memory controller, 28-bit address) into Wishbone B4 classic single-beat bus cycles.
- Sits between the memory controller WB port and the SoC Wishbone interconnect.
- Adds a bus timeout so a dead slave cannot stall the core forever.

Parameters:
- ADDR_WIDTH, 28, width of request and Wishbone address.
- TIMEOUT_CYCLES, 255, cycles in ACTIVE before abort; 0 disables timeout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- reqAddress  input  ADDR_WIDTH  request address
- reqByteSelect  input  4  byte lanes
- reqEnable  input  1  request valid, held until completion
- reqWriteEnable  input  1  1=write
- reqDataWrite  input  32  write data
- reqDataRead  output  32  read data, valid when reqBusy=0
- reqBusy  output  1  0 only on the completion cycle
- wb_cyc_o  output  1  bus cycle
- wb_stb_o  output  1  strobe
- wb_we_o  output  1  write enable
- wb_sel_o  output  4  byte select
- wb_adr_o  output  ADDR_WIDTH  address
- wb_dat_o  output  32  write data
- wb_dat_i  input  32  read data
- wb_ack_i  input  1  slave acknowledge
- wb_err_i  input  1  slave error

Behaviour:
- Reset values:
  - state=IDLE, reqBusy=1, reqDataRead=32'hFFFF_FFFF.
  - All wb_* outputs 0; timeout counter 0.
- All outputs are registered. Bridge is in one of three states: IDLE, ACTIVE, DONE.
- IDLE:
  - reqBusy=1.
  - On reqEnable=1, latch address, sel, we and write data into the wb_* output registers; set cyc=stb=1; go to ACTIVE.
  - First bus cycle is therefore at N+1 for a request sampled at N.
- ACTIVE:
  - cyc, stb and the latched fields are held stable; request inputs are ignored.
  - Counter increments each cycle.
  - wb_err_i=1 → go to DONE, data=32'hFFFF_FFFF. err has priority if ack and err arrive together.
  - Else wb_ack_i=1 → go to DONE, data=wb_dat_i (captured for reads; writes also return wb_dat_i).
  - Else counter==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES≠0 → go to DONE, data=32'hFFFF_FFFF.
  - On any exit, cyc and stb drop at the same edge and the counter clears.
- DONE:
  - Lasts exactly 1 cycle: reqBusy=0, reqDataRead holds the result. Next state is IDLE.
  - An ack at edge M gives reqBusy=0 during cycle M+1. Minimum latency is request to completion in 3 cycles.
- Back-to-back requests:
  - A requester holding reqEnable through DONE is sampled again in IDLE and starts a new transaction.
  - The same request is never re-issued within DONE.
- Request withdrawn mid-ACTIVE (reqEnable=0):
  - The bus cycle still runs to ack/err/timeout; classic cycles are not aborted.
  - DONE still occurs; the result is discarded by the requester.
- reqDataRead retains its last value outside DONE.
- Reset mid-ACTIVE: cyc and stb deassert at the reset edge; state goes to IDLE; no completion is signalled.
- Spurious ack/err in IDLE or DONE is ignored.

Optional Feature:
- Macro: WB_BRIDGE_ERROR_STATUS_EN.
- Defined: adds ports errorClear (input 1), errorFlag (output 1) and errorAddress (output ADDR_WIDTH).
  - errorFlag sets on err or timeout; errorAddress captures wb_adr_o at that event; both are sticky.
  - errorClear=1 clears both next edge; a set on the same cycle wins over clear.
  - Reset value of both outputs: 0.
- Undefined: ports absent; errors are only visible as the 32'hFFFF_FFFF read data.

Decomposition:
- Shared package wb_bridge_pkg:
  - state enum (IDLE, ACTIVE, DONE);
  - WB_ERROR_DATA=32'hFFFF_FFFF;
  - function for timeout counter width ($clog2(TIMEOUT_CYCLES+1), min 1).
- Sub-module wb_timeout_counter:
  - inputs: clk, rst, run, clear;
  - output: expired;
  - parameterised on TIMEOUT_CYCLES; tied to expired=0 when TIMEOUT_CYCLES=0.

Test Plan:
- Read: address 28'h0001004, slave acks on the 2nd ACTIVE cycle with 32'hCAFE_F00D → wb_adr_o=28'h0001004, we=0, sel=4'hF; reqBusy=0 for exactly one cycle, 4 cycles after the request; reqDataRead=32'hCAFE_F00D.
- Write: address 28'h0000010, sel=4'b0011, data 32'h1234_5678, immediate ack → wb_we_o=1, wb_dat_o=32'h1234_5678, sel=4'b0011; completion 3 cycles after the request; cyc low in DONE.
- Error priority: ack and err asserted together → reqDataRead=32'hFFFF_FFFF. With the macro defined: errorFlag=1 and errorAddress = the request address; errorClear pulse → both 0.
- Timeout: TIMEOUT_CYCLES=8, no ack → cyc held exactly 8 cycles then dropped; reqBusy=0 with 32'hFFFF_FFFF. TIMEOUT_CYCLES=0, no ack for 1000 cycles → cyc still high.
- Back-to-back: reqEnable held, address changes 28'h100→28'h104 in DONE → two distinct bus cycles with one idle cycle between; no duplicate access to 28'h100.
- Reset mid-ACTIVE: rst at the 3rd ACTIVE cycle, then an ack arrives → wb_cyc_o=0 after the reset edge; the late ack is ignored; reqBusy stays 1.
